gpio_in_filter: RTL

//  Consumes raw GPIO input data (read_data from the bidir I/O stage) and produces

---
 rtl/gpio_in_filter_if.sv | 22 ++
 rtl/gpio_in_filter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter_if.sv
// Register-bus bundle for gpio_in_filter: one-cycle read/write strobes,
// word address, write data and registered read data.
interface gpio_in_filter_if #(
    parameter int AddrWidth = 16,
    parameter int BusWidth  = 32
);
    logic                 write_reg;
    logic                 read_reg;
    logic [AddrWidth-3:0] busaddress;
    logic [BusWidth-1:0]  busdata_in;
    logic [BusWidth-1:0]  busdata_out;

    modport master (
        output write_reg, read_reg, busaddress, busdata_in,
        input  busdata_out
    );

    modport slave (
        input  write_reg, read_reg, busaddress, busdata_in,
        output busdata_out
    );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: synchronizes and deglitches raw GPIO input bits, latches
// rise/fall events (sticky, write-1-to-clear) and exposes level, events and
// filter configuration on the register bus at 0x1400-0x1423.
// Optional feature macro: GPIO_IN_FILTER_IRQ_EN adds the MASK registers and a
// registered event interrupt; without it MASK reads 0 and irq is tied low.
module gpio_in_filter #(
    parameter int AddrWidth = 16,
    parameter int BusWidth  = 32,
    parameter int InWidth   = 34,
    parameter int PreWidth  = 16,
    parameter int CntWidth  = 3
) (
    input  logic               reg_clk,
    input  logic               reset_reg,
    gpio_in_filter_if.slave    bus,
    input  logic [InWidth-1:0] raw_in,
    output logic [InWidth-1:0] filt_out,
    output logic               irq
);
    localparam int HiW = InWidth - BusWidth;
    localparam int unsigned WBASE = 32'h1400 >> 2;
    localparam logic [AddrWidth-3:0] A_CFG     = (AddrWidth-2)'(WBASE + 0);
    localparam logic [AddrWidth-3:0] A_LVL_LO  = (AddrWidth-2)'(WBASE + 1);
    localparam logic [AddrWidth-3:0] A_LVL_HI  = (AddrWidth-2)'(WBASE + 2);
    localparam logic [AddrWidth-3:0] A_RISE_LO = (AddrWidth-2)'(WBASE + 3);
    localparam logic [AddrWidth-3:0] A_RISE_HI = (AddrWidth-2)'(WBASE + 4);
    localparam logic [AddrWidth-3:0] A_FALL_LO = (AddrWidth-2)'(WBASE + 5);
    localparam logic [AddrWidth-3:0] A_FALL_HI = (AddrWidth-2)'(WBASE + 6);
`ifdef GPIO_IN_FILTER_IRQ_EN
    localparam logic [AddrWidth-3:0] A_MASK_LO = (AddrWidth-2)'(WBASE + 7);
    localparam logic [AddrWidth-3:0] A_MASK_HI = (AddrWidth-2)'(WBASE + 8);
`endif

    // bus capture
    logic                 r_wr, r_rd;
    logic [AddrWidth-3:0] r_waddr, r_raddr;
    logic [BusWidth-1:0]  r_wdata, r_rdata;

    // input path and filter state
    logic [InWidth-1:0]               r_sync1, r_sync2;
    logic [InWidth-1:0]               r_filt, r_rise, r_fall;
    logic [InWidth-1:0][CntWidth-1:0] r_cnt;
    logic [PreWidth-1:0]              r_prescale, r_pre;
    logic [CntWidth-1:0]              r_thr;

    logic                             w_cfg_wr, w_tick;
    logic [InWidth-1:0]               w_filt_nxt;
    logic [InWidth-1:0][CntWidth-1:0] w_cnt_nxt;
    logic [InWidth-1:0]               w_rise_ev, w_fall_ev;
    logic [InWidth-1:0]               w_wmask_lo, w_wmask_hi;
    logic [InWidth-1:0]               w_clr_rise, w_clr_fall;
    logic [BusWidth-1:0]              w_rdata;

    // Capture strobes, address and data; the action happens one edge later.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_waddr <= '0;
            r_raddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wr    <= bus.write_reg;
            r_rd    <= bus.read_reg;
            r_waddr <= bus.busaddress;
            r_raddr <= bus.busaddress;
            r_wdata <= bus.busdata_in;
        end
    end

    // Two-flop synchronizer per input bit.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cfg_wr = r_wr && (r_waddr == A_CFG);

    // CFG register: PRESCALE in [15:0], THRESH in [18:16].
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_prescale <= '0;
            r_thr      <= '0;
        end else if (w_cfg_wr) begin
            r_prescale <= r_wdata[PreWidth-1:0];
            r_thr      <= r_wdata[16 +: CntWidth];
        end
    end

    assign w_tick = (r_pre == r_prescale);

    // Prescaler counts 0..PRESCALE and restarts on any CFG write.
    always_ff @(posedge reg_clk) begin
        if (reset_reg)
            r_pre <= '0;
        else if (w_cfg_wr || w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + PreWidth'(1);
    end

    // Per-bit filter: a level must disagree for THRESH ticks before it is taken.
    always_comb begin
        w_filt_nxt = r_filt;
        w_cnt_nxt  = r_cnt;
        for (int i = 0; i < InWidth; i++) begin
            if (w_cfg_wr) begin
                w_cnt_nxt[i] = '0;
            end else if (r_thr == '0) begin
                w_filt_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]  = '0;
            end else if (w_tick) begin
                if (r_sync2[i] == r_filt[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] >= r_thr - CntWidth'(1)) begin
                    w_filt_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i]  = '0;
                end else if (r_cnt[i] != '1) begin
                    w_cnt_nxt[i] = r_cnt[i] + CntWidth'(1);
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_filt <= '0;
            r_cnt  <= '0;
        end else begin
            r_filt <= w_filt_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign w_rise_ev  = w_filt_nxt & ~r_filt;
    assign w_fall_ev  = r_filt & ~w_filt_nxt;
    assign w_wmask_lo = {{HiW{1'b0}}, r_wdata};
    assign w_wmask_hi = {r_wdata[HiW-1:0], {BusWidth{1'b0}}};
    assign w_clr_rise = !r_wr ? '0 :
                        (r_waddr == A_RISE_LO) ? w_wmask_lo :
                        (r_waddr == A_RISE_HI) ? w_wmask_hi : '0;
    assign w_clr_fall = !r_wr ? '0 :
                        (r_waddr == A_FALL_LO) ? w_wmask_lo :
                        (r_waddr == A_FALL_HI) ? w_wmask_hi : '0;

    // Sticky event latches; a new event beats a same-cycle clear.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_clr_rise) | w_rise_ev;
            r_fall <= (r_fall & ~w_clr_fall) | w_fall_ev;
        end
    end

`ifdef GPIO_IN_FILTER_IRQ_EN
    logic [InWidth-1:0] r_mask;
    logic               r_irq;

    // Interrupt mask, split into LO/HI words like the event registers.
    always_ff @(posedge reg_clk) begin
        if (reset_reg)
            r_mask <= '0;
        else if (r_wr && r_waddr == A_MASK_LO)
            r_mask <= {r_mask[InWidth-1:BusWidth], r_wdata};
        else if (r_wr && r_waddr == A_MASK_HI)
            r_mask <= {r_wdata[HiW-1:0], r_mask[BusWidth-1:0]};
    end

    // Interrupt follows the latched events one cycle behind.
    always_ff @(posedge reg_clk) begin
        if (reset_reg)
            r_irq <= 1'b0;
        else
            r_irq <= |((r_rise | r_fall) & r_mask);
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Read mux over the register map; unmapped words read zero.
    always_comb begin
        w_rdata = '0;
        case (r_raddr)
            A_CFG:     w_rdata = BusWidth'({r_thr, r_prescale});
            A_LVL_LO:  w_rdata = r_filt[BusWidth-1:0];
            A_LVL_HI:  w_rdata = BusWidth'(r_filt[InWidth-1:BusWidth]);
            A_RISE_LO: w_rdata = r_rise[BusWidth-1:0];
            A_RISE_HI: w_rdata = BusWidth'(r_rise[InWidth-1:BusWidth]);
            A_FALL_LO: w_rdata = r_fall[BusWidth-1:0];
            A_FALL_HI: w_rdata = BusWidth'(r_fall[InWidth-1:BusWidth]);
`ifdef GPIO_IN_FILTER_IRQ_EN
            A_MASK_LO: w_rdata = r_mask[BusWidth-1:0];
            A_MASK_HI: w_rdata = BusWidth'(r_mask[InWidth-1:BusWidth]);
`endif
            default:   w_rdata = '0;
        endcase
    end

    // Read data register: loads only on a captured read, then holds.
    always_ff @(posedge reg_clk) begin
        if (reset_reg)
            r_rdata <= '0;
        else if (r_rd)
            r_rdata <= w_rdata;
    end

    assign bus.busdata_out = r_rdata;
    assign filt_out        = r_filt;
endmodule
